// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic unit and its sequential divider.
// Both blocks take their state encoding, op codes and divider latency from here.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10
    } arith_op_t;

    // Clock edges from the accepted start to the edge that raises done.
    function automatic int unsigned DIV_LAT(input int unsigned width);
        return 2 * width + 1;
    endfunction

endpackage

// File: rtl/arith_divider_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor, keep the difference when it does not borrow.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             din,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             qbit
);

    localparam int REM_W = WIDTH + 1;

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        shifted = {rem_in, din};
        diff    = shifted - {2'b00, divisor};
        qbit    = (shifted >= {2'b00, divisor});
        // The partial remainder stays below the divisor, so the top bit of
        // either candidate is always zero and can be dropped.
        rem_out = REM_W'(qbit ? diff : shifted);
    end

endmodule

// File: rtl/arith_divider.sv
// Sequential unsigned divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock behind a start/busy/done handshake.
module arith_divider #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero
);

    import arith_pkg::*;

    localparam int             CW       = $clog2(2 * WIDTH + 1);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(2 * WIDTH);

    div_state_t         state_reg, state_next;
    logic [CW-1:0]      count_reg, count_next;
    logic [2*WIDTH-1:0] dividend_reg, dividend_next;
    logic [WIDTH-1:0]   divisor_reg, divisor_next;
    logic [WIDTH:0]     rem_reg, rem_next;
    logic [2*WIDTH-1:0] quotient_reg, quotient_next;
    logic               dbz_reg, dbz_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;

    logic               accept;
    logic [WIDTH:0]     step_rem;
    logic               step_qbit;

    div_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .rem_in  (rem_reg),
        .din     (dividend_reg[2*WIDTH-1]),
        .divisor (divisor_reg),
        .rem_out (step_rem),
        .qbit    (step_qbit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            dividend_reg <= '0;
            divisor_reg  <= '0;
            rem_reg      <= '0;
            quotient_reg <= '0;
            dbz_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            dividend_reg <= dividend_next;
            divisor_reg  <= divisor_next;
            rem_reg      <= rem_next;
            quotient_reg <= quotient_next;
            dbz_reg      <= dbz_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    // done is registered off the DONE state, so the pulse lands one cycle
    // after DONE is entered; busy covers that cycle so a start there is ignored.
    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        dividend_next = dividend_reg;
        divisor_next  = divisor_reg;
        rem_next      = rem_reg;
        quotient_next = quotient_reg;
        dbz_next      = dbz_reg;
        busy_next     = busy_reg;
        done_next     = (state_reg == DONE);
        accept        = start && !busy_reg;

        if (done_reg) begin
            busy_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    busy_next = 1'b1;
                    dbz_next  = 1'b0;
                    if (divisor == '0) begin
                        quotient_next = '1;
                        rem_next      = '0;
                        dbz_next      = 1'b1;
                        state_next    = DONE;
                    end else begin
                        dividend_next = dividend;
                        divisor_next  = divisor;
                        rem_next      = '0;
                        quotient_next = '0;
                        count_next    = CNT_LOAD;
                        state_next    = RUN;
                    end
                end
            end
            RUN: begin
                rem_next      = step_rem;
                quotient_next = {quotient_reg[2*WIDTH-2:0], step_qbit};
                dividend_next = {dividend_reg[2*WIDTH-2:0], 1'b0};
                count_next    = count_reg - CW'(1);
                if (count_reg == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign quotient    = quotient_reg;
    assign remainder   = rem_reg[WIDTH-1:0];
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_arith_divider.sv
// Self-checking bench for arith_divider: directed literal cases plus a
// randomized start stream checked every cycle against an arithmetic model.
module tb_arith_divider;

    import arith_pkg::*;

    localparam int WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [2*WIDTH-1:0]   dividend = '0;
    logic [WIDTH-1:0]     divisor = '0;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 div_by_zero;

    int tests = 0;
    int fails = 0;

    arith_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks accepted operations by edge count only.
    int          cyc = 0;
    bit          m_active = 1'b0;
    int          m_done_edge = 0;
    logic [15:0] m_q = '0;
    logic [7:0]  m_r = '0;
    logic        m_dz = 1'b0;

    initial begin
        bit busy_prev;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_active = 1'b0;
                m_q      = '0;
                m_r      = '0;
                m_dz     = 1'b0;
            end else begin
                busy_prev = m_active && (cyc <= m_done_edge);
                cyc++;
                if (start && !busy_prev) begin
                    m_active = 1'b1;
                    if (divisor == 0) begin
                        m_q         = 16'hFFFF;
                        m_r         = 8'd0;
                        m_dz        = 1'b1;
                        m_done_edge = cyc + 1;
                    end else begin
                        m_q         = dividend / {8'd0, divisor};
                        m_r         = 8'(dividend % {8'd0, divisor});
                        m_dz        = 1'b0;
                        m_done_edge = cyc + int'(DIV_LAT(WIDTH));
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("busy", 32'(busy), 32'(m_active && (cyc <= m_done_edge)));
            chk("done", 32'(done), 32'(m_active && (cyc == m_done_edge)));
            if (!m_active || cyc >= m_done_edge) begin
                chk("quotient", 32'(quotient), 32'(m_q));
                chk("remainder", 32'(remainder), 32'(m_r));
                chk("div_by_zero", 32'(div_by_zero), 32'(m_dz));
            end
        end
    end

    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) return;
        end
        chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic do_div(input logic [15:0] a, input logic [7:0] b, input logic [15:0] eq,
                          input logic [7:0] er, input logic edz, input int elat);
        int lat;
        @(posedge clk); #2;
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(lat);
        chk("latency", 32'(lat), 32'(elat));
        chk("lit_quotient", 32'(quotient), 32'(eq));
        chk("lit_remainder", 32'(remainder), 32'(er));
        chk("lit_dbz", 32'(div_by_zero), 32'(edz));
        $display("[TB] %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d", a, b, quotient, remainder, div_by_zero, lat);
    endtask

    initial begin
        int lat;
        int ndone;

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);

        do_div(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 17);
        @(negedge clk);
        chk("done_single_pulse", 32'(done), 32'd0);
        do_div(16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, 17);
        do_div(16'd0, 8'd9, 16'd0, 8'd0, 1'b0, 17);
        do_div(16'd3, 8'd200, 16'd0, 8'd3, 1'b0, 17);
        do_div(16'd200, 8'd1, 16'd200, 8'd0, 1'b0, 17);
        do_div(16'd5, 8'd0, 16'hFFFF, 8'd0, 1'b1, 1);
        do_div(16'd9, 8'd3, 16'd3, 8'd0, 1'b0, 17);

        // Starts during RUN and during the done cycle must be ignored.
        @(posedge clk); #2;
        start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 start = 1'b1; dividend = 16'd50; divisor = 8'd5;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(lat);
        chk("ignore_latency", 32'(lat), 32'd11);
        chk("ignore_quotient", 32'(quotient), 32'd142);
        chk("ignore_remainder", 32'(remainder), 32'd6);
        $display("[TB] 1000 / 7 with ignored starts -> q=%0d r=%0d", quotient, remainder);
        start = 1'b1; dividend = 16'd50; divisor = 8'd5;
        @(posedge clk);
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(lat);
        chk("b2b_latency", 32'(lat), 32'd17);
        chk("b2b_quotient", 32'(quotient), 32'd10);
        chk("b2b_remainder", 32'(remainder), 32'd0);
        $display("[TB] 50 / 5 back-to-back -> q=%0d r=%0d", quotient, remainder);

        // Reset in the middle of RUN.
        @(posedge clk); #2;
        start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_quotient", 32'(quotient), 32'd0);
        chk("midrst_remainder", 32'(remainder), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midrst_no_done", 32'(ndone), 32'd0);
        $display("[TB] reset mid-run, done pulses afterwards=%0d", ndone);
        do_div(16'd100, 8'd3, 16'd33, 8'd1, 1'b0, 17);

        // Random start stream, occasional divide-by-zero and reset.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            start    = ($urandom_range(0, 2) == 0);
            dividend = 16'($urandom);
            divisor  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            if ($urandom_range(0, 3) == 0) dividend = 16'($urandom_range(0, 300));
            rst      = ($urandom_range(0, 499) == 0);
        end
        @(posedge clk); #2;
        start = 1'b0;
        rst   = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
